dram_arbiter: RTL and testbench
===============================

Name: dram_arbiter

Overview:
- Shares the single data memory (DRAM) port between N_CORES matrix-multiplier cores so several cores can compute different output tiles in parallel.
- Each core presents one access at a time over a req/gnt handshake. The arbiter serialises the accesses with round-robin fairness and drives the one physical DRAM port.
- It sits between the cores' DRAM address/read/write/data signals and the DRAM.

Parameters:
- N_CORES, 4, number of requesting cores (2..8).
- ADDR_W, 16, DRAM address width.
- DATA_W, 8, DRAM data width.
- RD_LAT, 1, DRAM read latency in cycles from read strobe to valid i_mem_rdata (≥1).

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_req  in  N_CORES  per-core access request, level.
- i_we  in  N_CORES  per-core access type: 1 = write, 0 = read.
- i_addr  in  N_CORES*ADDR_W  per-core address, packed; core k at bits [k*ADDR_W +: ADDR_W].
- i_wdata  in  N_CORES*DATA_W  per-core write data, packed the same way.
- o_gnt  out  N_CORES  one-hot grant; 1-cycle pulse acknowledging acceptance.
- o_rvalid  out  N_CORES  one-hot 1-cycle pulse: read data for that core is on o_rdata.
- o_rdata  out  DATA_W  read return data, broadcast to all cores; valid only with o_rvalid.
- o_mem_addr  out  ADDR_W  DRAM address.
- o_mem_read  out  1  DRAM read strobe.
- o_mem_write  out  1  DRAM write strobe.
- o_mem_wdata  out  DATA_W  DRAM write data.
- i_mem_rdata  in  DATA_W  DRAM read data.
- o_busy  out  1  high whenever state ≠ IDLE.

Behaviour:
- Reset (async, i_rst_n=0):
  - state=IDLE, rr_ptr=N_CORES-1 (so core 0 has first priority), latency counter=0.
  - All outputs 0: o_gnt, o_rvalid, o_rdata, o_mem_*, o_busy.
  - Asserting reset mid-transaction drops that transaction: no o_gnt, no o_rvalid, no strobe in the following cycle.
- FSM states: IDLE, ACCESS, RDWAIT.
- IDLE:
  - If |i_req == 0, stay in IDLE.
  - Otherwise the winner is the first requesting core scanning from rr_ptr+1 upward, modulo N_CORES.
  - At the clock edge, register win_idx, and capture that core's addr, we and wdata into o_mem_addr/o_mem_wdata registers.
  - Set rr_ptr=win_idx and move to ACCESS.
- ACCESS (exactly 1 cycle):
  - o_gnt[win_idx]=1.
  - o_mem_write=we_q, o_mem_read=~we_q, o_mem_addr/o_mem_wdata from the captured values.
  - If write, go to IDLE next. If read, load counter=RD_LAT and go to RDWAIT.
- RDWAIT:
  - Counter decrements each cycle; strobes are 0.
  - On the cycle counter==1, capture i_mem_rdata into o_rdata, pulse o_rvalid[win_idx] in the next cycle, and go to IDLE.
  - With RD_LAT=1, o_rvalid rises 2 cycles after o_gnt.
- Timing:
  - Latency from i_req sampled in IDLE to o_gnt: 1 cycle.
  - Throughput: write = 2 cycles per access; read = 2+RD_LAT cycles.
- Requester rules:
  - Hold i_req, i_we, i_addr and i_wdata stable until o_gnt is seen.
  - Deassert i_req in the cycle after o_gnt unless issuing a new access.
  - A reader must not issue its next request before its o_rvalid.
  - Withdrawing i_req before grant is legal; that core is simply not selected.
- Requests arriving while in ACCESS or RDWAIT are ignored until IDLE; they are not queued.
- Simultaneous requests from all cores: grants follow the order 0,1,…,N-1,0,…. No core waits more than N_CORES-1 other accesses.
- rr_ptr wrap-around: after N_CORES-1, the next scan starts at 0.
- o_gnt and o_rvalid are registered, glitch-free and at most one-hot. o_mem_read and o_mem_write are never both 1.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state enum {IDLE, ACCESS, RDWAIT};
  - localparam IDX_W = $clog2(N_CORES);
  - the default ADDR_W and DATA_W constants, shared with the core.
- One sub-module, rr_picker: combinational; inputs req vector and ptr; outputs win_idx and any_req. Uses a double-width rotate-and-priority-encode.
- The arbiter top holds the FSM, capture registers and latency counter.

Test Plan:
- After reset, core 2 alone writes addr 0x0104, data 0x5A → o_gnt=4'b0100 one cycle later; the same cycle has o_mem_write=1, o_mem_addr=0x0104, o_mem_wdata=0x5A; o_busy=0 the next cycle.
- Core 1 reads 0x0010 with DRAM returning 0x3C, RD_LAT=1 → o_gnt[1] at T, o_mem_read=1 at T, o_rvalid=4'b0010 with o_rdata=0x3C at T+2.
- All 4 cores keep requesting writes → grant order 0,1,2,3,0,1; one o_gnt every 2 cycles; o_gnt is never multi-hot.
- After core 3 is granted, cores 0 and 3 both request → core 0 wins (wrap-around); core 3 is granted next.
- i_rst_n pulled low during RDWAIT of a read → o_busy, o_rvalid and strobes go to 0 immediately; after release, no stale o_rvalid; core 0 has priority.
- Core 1 raises i_req during another core's ACCESS and drops it before IDLE → core 1 is never granted; no memory strobe occurs.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the DRAM arbiter and the matrix cores.
// Default widths here match the core's DRAM interface.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT} state_e;

  localparam int N_CORES_DEF = 4;
  localparam int IDX_W       = $clog2(N_CORES_DEF);
  localparam int ADDR_W_DEF  = 16;
  localparam int DATA_W_DEF  = 8;
  localparam int RD_LAT_DEF  = 1;
endpackage

// File: rtl/dram_arbiter_rr_picker.sv
// Round-robin winner select: first requester strictly after ptr_i, wrapping.
// Purely combinational; rotate the doubled request vector then priority-encode.
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] win_idx_o,
  output logic          any_req_o
);
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  localparam logic [IW:0]   NV   = (IW + 1)'(N);

  logic [IW-1:0] start;
  logic [N-1:0]  rot;
  logic [IW-1:0] off;
  logic [IW:0]   sum;

  always_comb begin
    start = (ptr_i == LAST) ? '0 : ptr_i + 1'b1;
    rot   = N'({req_i, req_i} >> start);
    off   = '0;
    // Descending scan so the lowest set bit (closest to start) wins.
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = IW'(i);
    end
    sum = {1'b0, start} + {1'b0, off};
    if (sum >= NV) sum = sum - NV;
    win_idx_o = sum[IW-1:0];
  end

  assign any_req_o = |req_i;
endmodule

// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing one DRAM port among N_CORES requesters.
// Grant 1 cycle after request in IDLE; writes take 2 cycles, reads 2+RD_LAT.
module dram_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_CORES = N_CORES_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RD_LAT  = RD_LAT_DEF
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [N_CORES-1:0]         i_req,
  input  logic [N_CORES-1:0]         i_we,
  input  logic [N_CORES*ADDR_W-1:0]  i_addr,
  input  logic [N_CORES*DATA_W-1:0]  i_wdata,
  output logic [N_CORES-1:0]         o_gnt,
  output logic [N_CORES-1:0]         o_rvalid,
  output logic [DATA_W-1:0]          o_rdata,
  output logic [ADDR_W-1:0]          o_mem_addr,
  output logic                       o_mem_read,
  output logic                       o_mem_write,
  output logic [DATA_W-1:0]          o_mem_wdata,
  input  logic [DATA_W-1:0]          i_mem_rdata,
  output logic                       o_busy
);
  localparam int WIN_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam int CNT_W = $clog2(RD_LAT + 1);

  state_e               state_q, state_d;
  logic [WIN_W-1:0]     rr_q, rr_d, win_q, win_d, pick;
  logic                 any_req;
  logic                 we_q, we_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d, rdata_q, rdata_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [N_CORES-1:0]   gnt_q, gnt_d, rvalid_q, rvalid_d;
  logic                 rd_q, rd_d, wr_q, wr_d;

  rr_picker #(.N(N_CORES), .IW(WIN_W)) u_picker (
    .req_i     (i_req),
    .ptr_i     (rr_q),
    .win_idx_o (pick),
    .any_req_o (any_req)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  state_d = we_q ? IDLE : RDWAIT;
      RDWAIT:  if (cnt_q == CNT_W'(1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values for the registered outputs and the capture datapath.
  always_comb begin
    rr_d     = rr_q;
    win_d    = win_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    gnt_d    = '0;
    rvalid_d = '0;
    rd_d     = 1'b0;
    wr_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          win_d       = pick;
          rr_d        = pick;
          we_d        = i_we[pick];
          addr_d      = i_addr[int'(pick)*ADDR_W +: ADDR_W];
          wdata_d     = i_wdata[int'(pick)*DATA_W +: DATA_W];
          gnt_d[pick] = 1'b1;
          wr_d        = i_we[pick];
          rd_d        = ~i_we[pick];
        end
      end
      ACCESS: begin
        if (!we_q) cnt_d = CNT_W'(RD_LAT);
      end
      RDWAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          rdata_d         = i_mem_rdata;
          rvalid_d[win_q] = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_q     <= WIN_W'(N_CORES - 1);
      win_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      gnt_q    <= '0;
      rvalid_q <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
    end else begin
      rr_q     <= rr_d;
      win_q    <= win_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
    end
  end

  assign o_gnt       = gnt_q;
  assign o_rvalid    = rvalid_q;
  assign o_rdata     = rdata_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_mem_read  = rd_q;
  assign o_mem_write = wr_q;
  assign o_busy      = (state_q != IDLE);
endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: directed scenarios plus a randomized run against a
// transaction-level round-robin model.
module tb_dram_arbiter;
  localparam int N      = 4;
  localparam int AW     = 16;
  localparam int DW     = 8;
  localparam int RD_LAT = 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req, we;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    gnt, rvalid;
  logic [DW-1:0]   rdata, mem_wdata, mem_rdata;
  logic [AW-1:0]   mem_addr;
  logic            mem_read, mem_write, busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  dram_arbiter #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req       (req),
    .i_we        (we),
    .i_addr      (addr),
    .i_wdata     (wdata),
    .o_gnt       (gnt),
    .o_rvalid    (rvalid),
    .o_rdata     (rdata),
    .o_mem_addr  (mem_addr),
    .o_mem_read  (mem_read),
    .o_mem_write (mem_write),
    .o_mem_wdata (mem_wdata),
    .i_mem_rdata (mem_rdata),
    .o_busy      (busy)
  );

  function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h2C;
  endfunction

  // DRAM model with RD_LAT = 1: data follows the read strobe by one edge.
  initial mem_rdata = '0;
  always @(posedge clk) if (mem_read) mem_rdata <= mem_f(mem_addr);

  task automatic drive_core(input int k, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[k] = 1'b1;
    we[k]  = w;
    addr[k*AW +: AW]  = a;
    wdata[k*DW +: DW] = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; we = '0; addr = '0; wdata = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 4'hF; we = 4'hF; addr = '1; wdata = '1;
    #22;
    n_checks++; if (gnt !== 4'b0)       $display("FAIL rst_gnt got %b want 0000", gnt); else n_pass++;
    n_checks++; if (rvalid !== 4'b0)    $display("FAIL rst_rvalid got %b want 0000", rvalid); else n_pass++;
    n_checks++; if (rdata !== 8'h00)    $display("FAIL rst_rdata got %h want 00", rdata); else n_pass++;
    n_checks++; if (mem_addr !== 16'h0) $display("FAIL rst_mem_addr got %h want 0000", mem_addr); else n_pass++;
    n_checks++; if (mem_read !== 1'b0)  $display("FAIL rst_mem_read got %b want 0", mem_read); else n_pass++;
    n_checks++; if (mem_write !== 1'b0) $display("FAIL rst_mem_write got %b want 0", mem_write); else n_pass++;
    n_checks++; if (mem_wdata !== 8'h0) $display("FAIL rst_mem_wdata got %h want 00", mem_wdata); else n_pass++;
    n_checks++; if (busy !== 1'b0)      $display("FAIL rst_busy got %b want 0", busy); else n_pass++;
    req = '0; we = '0; addr = '0; wdata = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write();
    drive_core(2, 1'b1, 16'h0104, 8'h5A);
    @(negedge clk);
    n_checks++; if (gnt !== 4'b0100)       $display("FAIL wr_gnt got %b want 0100", gnt); else n_pass++;
    n_checks++; if (mem_write !== 1'b1)    $display("FAIL wr_strobe got %b want 1", mem_write); else n_pass++;
    n_checks++; if (mem_read !== 1'b0)     $display("FAIL wr_no_read got %b want 0", mem_read); else n_pass++;
    n_checks++; if (mem_addr !== 16'h0104) $display("FAIL wr_addr got %h want 0104", mem_addr); else n_pass++;
    n_checks++; if (mem_wdata !== 8'h5A)   $display("FAIL wr_wdata got %h want 5a", mem_wdata); else n_pass++;
    n_checks++; if (busy !== 1'b1)         $display("FAIL wr_busy got %b want 1", busy); else n_pass++;
    req = '0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0)      $display("FAIL wr_idle_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (gnt !== 4'b0)       $display("FAIL wr_idle_gnt got %b want 0000", gnt); else n_pass++;
    n_checks++; if (mem_write !== 1'b0) $display("FAIL wr_idle_strobe got %b want 0", mem_write); else n_pass++;
  endtask

  task automatic test_read();
    drive_core(1, 1'b0, 16'h0010, 8'h00);
    @(negedge clk);
    n_checks++; if (gnt !== 4'b0010)    $display("FAIL rd_gnt got %b want 0010", gnt); else n_pass++;
    n_checks++; if (mem_read !== 1'b1)  $display("FAIL rd_strobe got %b want 1", mem_read); else n_pass++;
    n_checks++; if (mem_write !== 1'b0) $display("FAIL rd_no_write got %b want 0", mem_write); else n_pass++;
    req = '0;
    @(negedge clk);
    n_checks++; if (rvalid !== 4'b0)   $display("FAIL rd_early_rvalid got %b want 0000", rvalid); else n_pass++;
    n_checks++; if (mem_read !== 1'b0) $display("FAIL rd_wait_strobe got %b want 0", mem_read); else n_pass++;
    n_checks++; if (busy !== 1'b1)     $display("FAIL rd_wait_busy got %b want 1", busy); else n_pass++;
    @(negedge clk);
    n_checks++; if (rvalid !== 4'b0010) $display("FAIL rd_rvalid got %b want 0010", rvalid); else n_pass++;
    n_checks++; if (rdata !== 8'h3C)    $display("FAIL rd_rdata got %h want 3c", rdata); else n_pass++;
    n_checks++; if (busy !== 1'b0)      $display("FAIL rd_done_busy got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] e;
    do_reset();
    for (int k = 0; k < N; k++) drive_core(k, 1'b1, AW'(16'h1000 + k), DW'(k));
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      e = (i % 2 == 0) ? N'(1 << ((i / 2) % N)) : '0;
      n_checks++; if (gnt !== e) $display("FAIL b2b_gnt[%0d] got %b want %b", i, gnt, e); else n_pass++;
      n_checks++; if ($countones(gnt) > 1) $display("FAIL b2b_onehot[%0d] got %b want at most one bit", i, gnt); else n_pass++;
      if (i == 11) req = '0;
    end
  endtask

  task automatic test_wrap();
    drive_core(3, 1'b1, 16'h0300, 8'h33);
    @(negedge clk);
    n_checks++; if (gnt !== 4'b1000) $display("FAIL wrap_gnt3 got %b want 1000", gnt); else n_pass++;
    drive_core(0, 1'b1, 16'h0000, 8'h11);
    @(negedge clk);
    n_checks++; if (gnt !== 4'b0000) $display("FAIL wrap_idle got %b want 0000", gnt); else n_pass++;
    @(negedge clk);
    n_checks++; if (gnt !== 4'b0001)       $display("FAIL wrap_gnt0 got %b want 0001", gnt); else n_pass++;
    n_checks++; if (mem_addr !== 16'h0000) $display("FAIL wrap_addr0 got %h want 0000", mem_addr); else n_pass++;
    req[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (gnt !== 4'b1000) $display("FAIL wrap_regnt3 got %b want 1000", gnt); else n_pass++;
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_reset_midread();
    drive_core(2, 1'b0, 16'h0222, 8'h00);
    @(negedge clk);
    n_checks++; if (gnt !== 4'b0100) $display("FAIL mrst_gnt got %b want 0100", gnt); else n_pass++;
    req = '0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b1) $display("FAIL mrst_pre_busy got %b want 1", busy); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0)      $display("FAIL mrst_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (rvalid !== 4'b0)    $display("FAIL mrst_rvalid got %b want 0000", rvalid); else n_pass++;
    n_checks++; if (mem_read !== 1'b0)  $display("FAIL mrst_read got %b want 0", mem_read); else n_pass++;
    n_checks++; if (mem_write !== 1'b0) $display("FAIL mrst_write got %b want 0", mem_write); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (rvalid !== 4'b0) $display("FAIL mrst_stale_rvalid[%0d] got %b want 0000", i, rvalid); else n_pass++;
    end
    drive_core(0, 1'b1, 16'h0A00, 8'hA0);
    drive_core(3, 1'b1, 16'h0A03, 8'hA3);
    @(negedge clk);
    n_checks++; if (gnt !== 4'b0001) $display("FAIL mrst_prio got %b want 0001", gnt); else n_pass++;
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_withdraw();
    drive_core(0, 1'b0, 16'h0040, 8'h00);
    @(negedge clk);
    n_checks++; if (gnt !== 4'b0001) $display("FAIL wd_gnt0 got %b want 0001", gnt); else n_pass++;
    req[0] = 1'b0;
    drive_core(1, 1'b1, 16'h0100, 8'h77);
    @(negedge clk);
    req[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++; if (gnt !== 4'b0) $display("FAIL wd_gnt[%0d] got %b want 0000", i, gnt); else n_pass++;
      n_checks++; if ((mem_read | mem_write) !== 1'b0) $display("FAIL wd_strobe[%0d] got %b%b want 00", i, mem_read, mem_write); else n_pass++;
      if (i == 0) begin
        n_checks++; if (rvalid !== 4'b0001) $display("FAIL wd_rvalid0 got %b want 0001", rvalid); else n_pass++;
      end
    end
  endtask

  // Model: an access may start at edge E once E reaches free_edge; winner is the
  // first requester after the last winner; reads return mem_f(addr) later.
  task automatic test_random();
    int last, free_edge, rv_edge, rv_core, win;
    bit acc;
    logic [N-1:0]  e_gnt, e_rv;
    logic          e_rd, e_wr, e_busy;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_rdata, rv_data;
    do_reset();
    last = N - 1; free_edge = 0; rv_edge = -1; rv_core = 0; rv_data = '0;
    e_addr = '0; e_wdata = '0; e_rdata = '0;
    for (int E = 0; E < 600; E++) begin
      req   = N'($urandom);
      we    = N'($urandom);
      addr  = {$urandom(), $urandom()};
      wdata = 32'($urandom);
      e_gnt = '0; e_rv = '0; e_rd = 1'b0; e_wr = 1'b0; acc = 1'b0;
      if (E == rv_edge) begin
        e_rv[rv_core] = 1'b1;
        e_rdata = rv_data;
      end
      if (E >= free_edge && req != '0) begin
        win = -1;
        for (int k = 1; k <= N; k++) begin
          if (win < 0 && req[(last + k) % N]) win = (last + k) % N;
        end
        last = win; acc = 1'b1;
        e_gnt[win] = 1'b1;
        e_addr  = addr[win*AW +: AW];
        e_wdata = wdata[win*DW +: DW];
        if (we[win]) begin
          e_wr = 1'b1;
          free_edge = E + 2;
        end else begin
          e_rd = 1'b1;
          free_edge = E + 2 + RD_LAT;
          rv_edge = E + 1 + RD_LAT;
          rv_core = win;
          rv_data = mem_f(e_addr);
        end
      end
      e_busy = acc || (E < free_edge - 1);
      @(negedge clk);
      n_checks++; if (gnt !== e_gnt)     $display("FAIL rnd_gnt@%0d got %b want %b", E, gnt, e_gnt); else n_pass++;
      n_checks++; if (mem_read !== e_rd)  $display("FAIL rnd_read@%0d got %b want %b", E, mem_read, e_rd); else n_pass++;
      n_checks++; if (mem_write !== e_wr) $display("FAIL rnd_write@%0d got %b want %b", E, mem_write, e_wr); else n_pass++;
      n_checks++; if (rvalid !== e_rv)   $display("FAIL rnd_rvalid@%0d got %b want %b", E, rvalid, e_rv); else n_pass++;
      n_checks++; if (busy !== e_busy)   $display("FAIL rnd_busy@%0d got %b want %b", E, busy, e_busy); else n_pass++;
      if (acc) begin
        n_checks++; if (mem_addr !== e_addr) $display("FAIL rnd_addr@%0d got %h want %h", E, mem_addr, e_addr); else n_pass++;
        if (e_wr) begin
          n_checks++; if (mem_wdata !== e_wdata) $display("FAIL rnd_wdata@%0d got %h want %h", E, mem_wdata, e_wdata); else n_pass++;
        end
      end
      if (e_rv != '0) begin
        n_checks++; if (rdata !== e_rdata) $display("FAIL rnd_rdata@%0d got %h want %h", E, rdata, e_rdata); else n_pass++;
      end
    end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_wrap();
    test_reset_midread();
    test_withdraw();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
